fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, fetch FSM states and PC helpers.
package cpu_types_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // Clears the byte-offset bits so every fetch address is word aligned.
  function automatic word_t word_align(input word_t addr);
    return addr & ~WORD_W'(BYTES_PER_WORD - 1);
  endfunction

  // Sequential next address; wraps modulo 2^32.
  function automatic word_t next_word(input word_t addr);
    return addr + WORD_W'(BYTES_PER_WORD);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of fetch-unit signals; imemload is what the control unit decodes.
interface fetch_unit_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t iload;
  logic  iREN;
  word_t iaddr;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  word_t imemload;
  logic  instr_valid;
  word_t pc;
  word_t npc;
  logic  halted;

  modport fu (
    input  ihit, iload, stall, redirect, redirect_pc, halt,
    output iREN, iaddr, imemload, instr_valid, pc, npc, halted
  );

  modport tb (
    output ihit, iload, stall, redirect, redirect_pc, halt,
    input  iREN, iaddr, imemload, instr_valid, pc, npc, halted
  );

endinterface

// File: rtl/fetch_unit.sv
// Single-entry instruction fetch buffer with stall hold, redirect and sticky halt.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] iload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [WORD_W-1:0] imemload,
  output logic              instr_valid,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] npc,
  output logic              halted
);

  fetch_state_t state, next_state;

  word_t fetch_pc, fetch_pc_n;
  word_t ir, ir_n;
  word_t ir_pc, ir_pc_n;
  logic  ir_valid, ir_valid_n;
  logic  fetch_en;
  logic  accept;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= FETCH;
    else       state <= next_state;
  end

  // Next-state: halt leaves FETCH only with a live instruction and no redirect
  always_comb begin
    next_state = state;
    case (state)
      FETCH:   if (!redirect && halt && ir_valid) next_state = HALTED;
      HALTED:  next_state = HALTED;
      default: next_state = FETCH;
    endcase
  end

  // Buffer registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_pc <= PC_INIT;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      fetch_pc <= fetch_pc_n;
      ir       <= ir_n;
      ir_pc    <= ir_pc_n;
      ir_valid <= ir_valid_n;
    end
  end

  // Buffer update: redirect beats halt beats a returning fetch beats consumption
  always_comb begin
    fetch_pc_n = fetch_pc;
    ir_n       = ir;
    ir_pc_n    = ir_pc;
    ir_valid_n = ir_valid;
    fetch_en   = (state == FETCH) && (!ir_valid || !stall);
    accept     = fetch_en && ihit;

    if (state == HALTED) begin
      ir_valid_n = 1'b0;
    end else if (redirect) begin
      fetch_pc_n = word_align(redirect_pc);
      ir_valid_n = 1'b0;
    end else if (halt && ir_valid) begin
      ir_valid_n = 1'b0;
    end else if (accept) begin
      ir_n       = iload;
      ir_pc_n    = fetch_pc;
      ir_valid_n = 1'b1;
      fetch_pc_n = next_word(fetch_pc);
    end else if (ir_valid && !stall) begin
      ir_valid_n = 1'b0;
    end
  end

  // Outputs; the read request is also suppressed while reset is held
  always_comb begin
    iREN        = nRST && fetch_en;
    iaddr       = fetch_pc;
    imemload    = ir_valid ? ir : '0;
    instr_valid = ir_valid;
    pc          = ir_pc;
    npc         = next_word(ir_pc);
    halted      = (state == HALTED);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: accepted fetches are queued and checked on output.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  localparam word_t PC_INIT = 32'h0000_0000;

  typedef struct packed {
    word_t addr;
    word_t data;
  } exp_t;

  logic CLK;
  logic nRST;
  fetch_unit_if fif ();

  fetch_unit #(.PC_INIT(PC_INIT)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (fif.ihit),
    .iload       (fif.iload),
    .iREN        (fif.iREN),
    .iaddr       (fif.iaddr),
    .stall       (fif.stall),
    .redirect    (fif.redirect),
    .redirect_pc (fif.redirect_pc),
    .halt        (fif.halt),
    .imemload    (fif.imemload),
    .instr_valid (fif.instr_valid),
    .pc          (fif.pc),
    .npc         (fif.npc),
    .halted      (fif.halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  exp_t  exp_q[$];
  word_t m_fpc;
  word_t m_pc;
  word_t m_ir;
  logic  m_valid;
  logic  m_halted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_fpc    = PC_INIT;
    m_valid  = 1'b0;
    m_halted = 1'b0;
    m_pc     = '0;
    m_ir     = '0;
    exp_q.delete();
  endtask

  task automatic drive_idle();
    fif.ihit        = 1'b0;
    fif.iload       = '0;
    fif.stall       = 1'b0;
    fif.redirect    = 1'b0;
    fif.redirect_pc = '0;
    fif.halt        = 1'b0;
  endtask

  // Hold reset across an edge, check the reset outputs, release between edges.
  task automatic do_reset();
    nRST = 1'b0;
    drive_idle();
    @(posedge CLK);
    #1;
    check("rst_iren",   32'(fif.iREN), 32'd0);
    check("rst_valid",  32'(fif.instr_valid), 32'd0);
    check("rst_halted", 32'(fif.halted), 32'd0);
    check("rst_iaddr",  fif.iaddr, PC_INIT);
    check("rst_imem",   fif.imemload, 32'd0);
    nRST = 1'b1;
    model_reset();
  endtask

  // One clock: drive inputs, check request side, clock, check buffer side.
  task automatic cyc(input logic h, input word_t ld, input logic st,
                     input logic rd, input word_t rpc, input logic hl);
    logic acc;
    logic ren;
    exp_t e;
    fif.ihit        = h;
    fif.iload       = ld;
    fif.stall       = st;
    fif.redirect    = rd;
    fif.redirect_pc = rpc;
    fif.halt        = hl;
    #1;
    ren = !m_halted && (!m_valid || !st);
    check("iren",  32'(fif.iREN), 32'(ren));
    check("iaddr", fif.iaddr, m_fpc);
    acc = 1'b0;
    if (!m_halted) begin
      if (rd) begin
        m_fpc   = {rpc[31:2], 2'b00};
        m_valid = 1'b0;
      end else if (hl && m_valid) begin
        m_halted = 1'b1;
        m_valid  = 1'b0;
      end else if (ren && h) begin
        exp_q.push_back('{addr: m_fpc, data: ld});
        m_fpc   = m_fpc + 32'd4;
        m_valid = 1'b1;
        acc     = 1'b1;
      end else if (m_valid && !st) begin
        m_valid = 1'b0;
      end
    end
    @(posedge CLK);
    #1;
    if (acc) begin
      e    = exp_q.pop_front();
      m_pc = e.addr;
      m_ir = e.data;
    end
    check("valid",  32'(fif.instr_valid), 32'(m_valid));
    check("halted", 32'(fif.halted), 32'(m_halted));
    if (m_valid) begin
      check("imemload", fif.imemload, m_ir);
      check("pc",       fif.pc, m_pc);
      check("npc",      fif.npc, m_pc + 32'd4);
    end else begin
      check("imem_idle", fif.imemload, 32'd0);
    end
  endtask

  initial begin
    nRST = 1'b0;
    drive_idle();
    model_reset();
    @(posedge CLK);
    do_reset();

    // Back-to-back hits from reset: addresses 0, 4, 8
    cyc(1'b1, 32'h2401_0001, 1'b0, 1'b0, 32'h0, 1'b0);
    check("first_pc",  fif.pc, 32'h0);
    check("first_npc", fif.npc, 32'h4);
    check("first_vld", 32'(fif.instr_valid), 32'd1);
    cyc(1'b1, 32'h2401_0001, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h2401_0001, 1'b0, 1'b0, 32'h0, 1'b0);

    // Stall holds the buffered instruction; hits are ignored
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0);
      check("stall_pc", fif.pc, 32'h8);
    end
    check("stall_iaddr", fif.iaddr, 32'hC);
    cyc(1'b1, 32'h2402_0002, 1'b0, 1'b0, 32'h0, 1'b0);
    check("resume_pc", fif.pc, 32'hC);

    // Redirect drops a same-cycle hit and aligns the target
    cyc(1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
    check("redir_iaddr", fif.iaddr, 32'h0000_0100);
    check("redir_valid", 32'(fif.instr_valid), 32'd0);
    cyc(1'b1, 32'h2403_0003, 1'b0, 1'b0, 32'h0, 1'b0);

    // Mixed traffic
    for (int i = 0; i < 40; i++) begin
      cyc(1'($urandom_range(0, 1)), word_t'($urandom()),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
          word_t'($urandom_range(0, 255)) << 4, 1'b0);
    end

    // Address wrap at the top of memory
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cyc(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0, 1'b0);
    check("wrap_pc",    fif.pc, 32'hFFFF_FFFC);
    check("wrap_npc",   fif.npc, 32'h0);
    check("wrap_iaddr", fif.iaddr, 32'h0);

    // Halt squashed by a same-cycle redirect
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
    check("squash_halted", 32'(fif.halted), 32'd0);
    cyc(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b0);

    // Halt with a live instruction is sticky
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("halt_set", 32'(fif.halted), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h1234_5678, 1'($urandom_range(0, 1)), 1'b1, 32'h0000_0300, 1'b0);
      check("halt_iren", 32'(fif.iREN), 32'd0);
    end

    // Reset pulsed mid-stall takes effect without a clock edge
    do_reset();
    cyc(1'b1, 32'h2404_0004, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h5555_5555, 1'b1, 1'b0, 32'h0, 1'b0);
    nRST = 1'b0;
    #1;
    check("async_valid", 32'(fif.instr_valid), 32'd0);
    check("async_iren",  32'(fif.iREN), 32'd0);
    check("async_iaddr", fif.iaddr, PC_INIT);
    check("async_imem",  fif.imemload, 32'd0);
    drive_idle();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    model_reset();
    cyc(1'b1, 32'h2405_0005, 1'b0, 1'b0, 32'h0, 1'b0);
    check("post_rst_pc", fif.pc, PC_INIT);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
